// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: write pointer, rptr synchroniser and registered full flag.
// Optional almost-full output enabled by defining FIFO_WR_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int P_SIZE      = 4,
  parameter int SYNC_STAGES = 2
`ifdef FIFO_WR_ALMOST_FULL_EN
  , parameter int AF_THRESH = 6
`endif
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              W_INC,
  input  logic [P_SIZE-1:0] rptr_gray,
  output logic              wclk_en,
  output logic [P_SIZE-2:0] waddr,
  output logic [P_SIZE-1:0] wptr_gray,
  output logic              WFULL,
  output logic              wr_overflow
`ifdef FIFO_WR_ALMOST_FULL_EN
  , output logic            WALMOST_FULL
`endif
);

  logic [P_SIZE-1:0] wbin;
  logic [P_SIZE-1:0] wbin_next;
  logic [P_SIZE-1:0] wgray_next;
  logic [P_SIZE-1:0] rq [SYNC_STAGES];
  logic [P_SIZE-1:0] rq_s;
  logic [P_SIZE-1:0] full_cmp;

  // W_RST gates the enable so no memory write can be issued while in reset.
  assign wclk_en    = W_INC & ~WFULL & W_RST;
  assign waddr      = wbin[P_SIZE-2:0];
  assign wbin_next  = wbin + {{(P_SIZE-1){1'b0}}, wclk_en};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  assign rq_s     = rq[SYNC_STAGES-1];
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~rq_s[P_SIZE-1:P_SIZE-2], rq_s[P_SIZE-3:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      WFULL       <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      WFULL       <= (wgray_next == full_cmp);
      wr_overflow <= wr_overflow | (W_INC & WFULL);
    end
  end

  // NOTE: the synchroniser is a register chain, not a memory, so each stage is reset explicitly.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) rq[k] <= '0;
    end else begin
      rq[0] <= rptr_gray;
      for (int k = 1; k < SYNC_STAGES; k++) rq[k] <= rq[k-1];
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  logic [P_SIZE-1:0] rbin_s;
  logic [P_SIZE-1:0] count;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < P_SIZE; i++) rbin_s[i] = ^(rq_s >> i);
  end

  assign count = wbin_next - rbin_s;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) WALMOST_FULL <= 1'b0;
    else        WALMOST_FULL <= (int'(count) >= AF_THRESH);
  end
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl at default parameters (depth 8).
// Exercises the almost-full output too when FIFO_WR_ALMOST_FULL_EN is defined.
module tb_fifo_wr_ctrl;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       W_INC = 1'b0;
  logic [3:0] rptr_gray = 4'h0;
  logic       wclk_en;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       WFULL;
  logic       wr_overflow;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic       WALMOST_FULL;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wr_ctrl dut (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .W_INC       (W_INC),
    .rptr_gray   (rptr_gray),
    .wclk_en     (wclk_en),
    .waddr       (waddr),
    .wptr_gray   (wptr_gray),
    .WFULL       (WFULL),
    .wr_overflow (wr_overflow)
`ifdef FIFO_WR_ALMOST_FULL_EN
    , .WALMOST_FULL (WALMOST_FULL)
`endif
  );

  always #5 W_CLK = ~W_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 2 time units past it, away from the edge.
  task automatic tick();
    @(posedge W_CLK);
    #2;
  endtask

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [3:0] exp_gray [8];
    logic [3:0] prev_gray;
    int wb;
    int wraps;
    exp_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};

    // 1. Reset, W_INC high inside reset must not issue a write.
    W_INC = 1'b1;
    #1;
    check("rst_wclk_en", 32'(wclk_en), 32'd0);
    check("rst_waddr",   32'(waddr),   32'd0);
    tick();
    W_INC = 1'b0;
    W_RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_wptr", 32'(wptr_gray),   32'h0);
      check("idle_addr", 32'(waddr),       32'd0);
      check("idle_full", 32'(WFULL),       32'd0);
      check("idle_ovf",  32'(wr_overflow), 32'd0);
      check("idle_wen",  32'(wclk_en),     32'd0);
    end

    // 2. Eight writes against rptr 0 fill the FIFO.
    W_INC = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("fill_addr", 32'(waddr),     32'(i));
      check("fill_wen",  32'(wclk_en),   32'd1);
      check("fill_gray", 32'(wptr_gray), 32'(exp_gray[i]));
      check("fill_full", 32'(WFULL),     32'd0);
      tick();
    end
    check("full_gray", 32'(wptr_gray), 32'hC);
    check("full_flag", 32'(WFULL),     32'd1);
    check("full_wen",  32'(wclk_en),   32'd0);
    W_INC = 1'b0;
    #1;
    check("full_ovf0", 32'(wr_overflow), 32'd0);

    // 3. Writes while full are rejected and set the sticky overflow.
    W_INC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_wen",  32'(wclk_en),     32'd0);
      check("ovf_gray", 32'(wptr_gray),   32'hC);
      check("ovf_addr", 32'(waddr),       32'd0);
      check("ovf_flag", 32'(wr_overflow), 32'd1);
    end
    W_INC = 1'b0;

    // 4. Read pointer 0->1: WFULL falls on the third edge after the change.
    rptr_gray = 4'h1;
    tick();
    check("rd_full_e1", 32'(WFULL), 32'd1);
    tick();
    check("rd_full_e2", 32'(WFULL), 32'd1);
    tick();
    check("rd_full_e3", 32'(WFULL), 32'd0);
    W_INC = 1'b1;
    #1;
    check("rd_wr_addr", 32'(waddr),   32'd0);
    check("rd_wr_wen",  32'(wclk_en), 32'd1);
    tick();
    check("rd_wr_gray", 32'(wptr_gray), 32'hD);
    check("rd_refull",  32'(WFULL),     32'd1);
    check("rd_ovf",     32'(wr_overflow), 32'd1);
    W_INC = 1'b0;

    // 5. Reader catches up to 9 in Gray steps, then 24 writes with the reader trailing.
    for (int r = 2; r <= 9; r++) begin
      rptr_gray = gray(4'(r));
      tick();
    end
    tick();
    tick();
    tick();
    check("drain_full", 32'(WFULL), 32'd0);
    wb = 9;
    wraps = 0;
    W_INC = 1'b1;
    #1;
    for (int i = 0; i < 24; i++) begin
      check("burst_addr", 32'(waddr),   32'(wb % 8));
      check("burst_wen",  32'(wclk_en), 32'd1);
      if (wb % 8 == 0) wraps++;
      prev_gray = wptr_gray;
      tick();
      wb++;
      rptr_gray = gray(4'(wb - 1));
      check("burst_gray", 32'(wptr_gray), 32'(gray(4'(wb))));
      check("burst_step", 32'($countones(prev_gray ^ wptr_gray)), 32'd1);
      check("burst_full", 32'(WFULL), 32'd0);
      #1;
    end
    W_INC = 1'b0;
    check("burst_wraps", 32'(wraps), 32'd3);
    check("ovf_sticky", 32'(wr_overflow), 32'd1);

    // 6. Reset clears overflow; then reset mid-burst at wbin=5.
    W_RST = 1'b0;
    rptr_gray = 4'h0;
    #1;
    check("rst2_ovf",  32'(wr_overflow), 32'd0);
    check("rst2_gray", 32'(wptr_gray),   32'h0);
    tick();
    W_RST = 1'b1;
    W_INC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("mid_addr5", 32'(waddr),     32'd5);
    check("mid_gray5", 32'(wptr_gray), 32'h7);
    W_RST = 1'b0;
    #1;
    check("mid_rst_wen",  32'(wclk_en),   32'd0);
    check("mid_rst_addr", 32'(waddr),     32'd0);
    check("mid_rst_gray", 32'(wptr_gray), 32'h0);
    tick();
    check("mid_hold_addr", 32'(waddr), 32'd0);
    check("mid_hold_wen",  32'(wclk_en), 32'd0);
    W_RST = 1'b1;
    #1;
    check("post_addr", 32'(waddr),   32'd0);
    check("post_wen",  32'(wclk_en), 32'd1);
    tick();
    check("post_gray",  32'(wptr_gray), 32'h1);
    check("post_addr1", 32'(waddr),     32'd1);
    W_INC = 1'b0;

`ifdef FIFO_WR_ALMOST_FULL_EN
    // Almost-full: threshold 6 reached on the sixth write against rptr 0.
    W_RST = 1'b0;
    #1;
    check("af_rst", 32'(WALMOST_FULL), 32'd0);
    tick();
    W_RST = 1'b1;
    W_INC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("af_5", 32'(WALMOST_FULL), 32'd0);
    tick();
    check("af_6", 32'(WALMOST_FULL), 32'd1);
    W_INC = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
